// File: rtl/regfile.sv
// Register file for the single-cycle datapath: two combinational read ports,
// one clocked write port, r0 hardwired to zero, optional write-to-read bypass.
module regfile #(
  parameter int n      = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic [n-1:0]  rd1,
  output logic [n-1:0]  rd2,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [n-1:0]  wd,
  output logic          wr_ok
);

  localparam int DEPTH = 2 ** AW;

  logic [n-1:0] mem [DEPTH];
  logic         wr_fire;

  // Write protocol: a write is accepted on the rising edge where we=1, rst=0
  // and wa!=0; there is no back-pressure, so every such edge updates mem.
  assign wr_fire = we && !rst && (wa != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ok <= 1'b0;
    end else begin
      wr_ok <= wr_fire;
      if (wr_fire) begin
        mem[wa] <= wd;
      end
    end
  end

  // Reads are asynchronous; the bypass only fires on a write that will land.
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : mem[ra1];
    rd2 = (ra2 == '0) ? '0 : mem[ra2];
    if (BYPASS != 0 && wr_fire) begin
      if (ra1 == wa) rd1 = wd;
      if (ra2 == wa) rd2 = wd;
    end
  end

endmodule

// File: tb/tb_regfile.sv
// Bench for regfile: drives a BYPASS=0 and a BYPASS=1 instance with the same
// stimulus and compares both against an array-based reference model.
module tb_regfile;

  localparam int N  = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] ra1, ra2, wa;
  logic          we;
  logic [N-1:0]  wd;

  logic [N-1:0]  rd1_b0, rd2_b0, rd1_b1, rd2_b1;
  logic          wr_ok_b0, wr_ok_b1;

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time budget");
    $fatal(1, "watchdog");
  end

  regfile #(.n(N), .AW(AW), .BYPASS(0)) dut_b0 (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b0), .rd2(rd2_b0),
    .we(we), .wa(wa), .wd(wd), .wr_ok(wr_ok_b0)
  );

  regfile #(.n(N), .AW(AW), .BYPASS(1)) dut_b1 (
    .clk(clk), .rst(rst), .ra1(ra1), .ra2(ra2), .rd1(rd1_b1), .rd2(rd2_b1),
    .we(we), .wa(wa), .wd(wd), .wr_ok(wr_ok_b1)
  );

  // reference model and scoreboard
  logic [N-1:0] model [32];
  logic         exp_q [$];
  logic         armed = 1'b0;
  int           vectors = 0;
  int           errs = 0;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, check reads/wr_ok at negedge, then advance the model.
  task automatic step(input logic r, input logic w, input logic [AW-1:0] a,
                      input logic [N-1:0] d, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    logic [N-1:0] old1, old2, byp1, byp2;
    logic         exp_wr;
    rst = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
    @(negedge clk);
    if (armed) begin
      old1 = model[r1];
      old2 = model[r2];
      byp1 = (w && !r && a != 0 && r1 == a) ? d : old1;
      byp2 = (w && !r && a != 0 && r2 == a) ? d : old2;
      check("rd1_b0", rd1_b0, old1);
      check("rd2_b0", rd2_b0, old2);
      check("rd1_b1", rd1_b1, byp1);
      check("rd2_b1", rd2_b1, byp2);
      if (exp_q.size() > 0) begin
        exp_wr = exp_q.pop_front();
        check("wr_ok_b0", {31'b0, wr_ok_b0}, {31'b0, exp_wr});
        check("wr_ok_b1", {31'b0, wr_ok_b1}, {31'b0, exp_wr});
      end else begin
        check("wr_ok_queue_empty", 32'd1, 32'd0);
      end
    end
    @(posedge clk);
    if (r) begin
      foreach (model[i]) model[i] = '0;
      armed = 1'b1;
      exp_q.push_back(1'b0);
    end else if (armed) begin
      if (w && a != 0) begin
        model[a] = d;
        exp_q.push_back(1'b1);
      end else begin
        exp_q.push_back(1'b0);
      end
    end
    #1;
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    step(1'b0, 1'b0, 5'd0, 32'h0, r1, r2);
  endtask

  logic [N-1:0] z;

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

    // 1: reset then sweep every address on both ports
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    for (int i = 0; i < 32; i++) idle(5'(i), 5'(31 - i));

    // 2: write r5, read back on both ports, wr_ok pulses once
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    idle(5'd5, 5'd5);
    idle(5'd5, 5'd5);

    // 3: write to r0 is ignored
    step(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // 4: write r7 while reading it (old value vs. bypass)
    step(1'b0, 1'b1, 5'd7, 32'h34, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd7, 32'h12, 5'd7, 5'd7);
    idle(5'd7, 5'd0);

    // 5: reset wins over a simultaneous write, and clears prior data
    step(1'b0, 1'b1, 5'd3, 32'h99, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd3, 32'h55, 5'd3, 5'd5);
    idle(5'd3, 5'd5);

    // 6: datapath loop r4 = r1 - r2 (ALU s=001)
    step(1'b0, 1'b1, 5'd1, 32'd10, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd2, 32'd3, 5'd0, 5'd0);
    z = model[1] - model[2];
    step(1'b0, 1'b1, 5'd4, z, 5'd1, 5'd2);
    idle(5'd4, 5'd4);
    check("r4_is_7", model[4], 32'd7);

    // randomized traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    idle(5'd0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
